param_mdu: RTL and testbench

PARAM_MDU -- requirements
Module: param_mdu

---
 rtl/mdu_pkg.sv | 35 +++
 rtl/mdu_arith.sv | 88 ++++++++
 rtl/param_mdu.sv | 112 +++++++++++
 tb/tb_param_mdu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - opcode encodings carried on the 4-bit op port
//   - the sequencer state enum (IDLE, RUN)
//   - the busy-counter width
//   - small opcode classification helpers used by the top and the datapath
package mdu_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ops that occupy the unit for a counted number of cycles.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op <= OP_DIVU) || ((op >= OP_MADD) && (op <= OP_MSUBU));
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result datapath for the multiply/divide unit.
// Ports:
//   op        latched opcode of the op being completed
//   src_a     latched rs operand (multiplicand / dividend)
//   src_b     latched rt operand (multiplier / divisor)
//   hi_in     current HI register value
//   lo_in     current LO register value
//   hi_out    HI value to commit when the op completes
//   lo_out    LO value to commit when the op completes
//   div_zero  divide op with a zero divisor; HI/LO must be held
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    prod_s;
  logic [W2-1:0]    prod_u;
  logic [W2-1:0]    acc;
  logic             signed_div;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Both products are taken mod 2^(2*WIDTH); the signed one uses
  // sign-extended operands so the low 2*WIDTH bits are the two's
  // complement product.
  assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
  assign prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
  assign acc    = {hi_in, lo_in};

  // Signed division works on magnitudes and restores signs afterwards:
  // the quotient is negative when the operand signs differ, the remainder
  // follows the dividend. Most-negative / -1 falls out naturally because
  // the magnitude quotient 2^(WIDTH-1) re-negates to itself.
  assign signed_div = (op == OP_DIV);
  assign neg_a      = signed_div & src_a[WIDTH-1];
  assign neg_b      = signed_div & src_b[WIDTH-1];
  assign mag_a      = neg_a ? (~src_a + 1'b1) : src_a;
  assign mag_b      = neg_b ? (~src_b + 1'b1) : src_b;
  assign div_zero   = is_div(op) && (src_b == '0);
  // Substitute a harmless divisor on zero so the divider never sees 0;
  // the result is discarded via div_zero anyway.
  assign divisor    = (src_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
  assign q_mag      = mag_a / divisor;
  assign r_mag      = mag_a % divisor;
  assign quot       = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
  assign rem        = neg_a ? (~r_mag + 1'b1) : r_mag;

  always_comb begin
    hi_out = hi_in;
    lo_out = lo_in;
    case (op)
      OP_MULT:  {hi_out, lo_out} = prod_s;
      OP_MULTU: {hi_out, lo_out} = prod_u;
      OP_DIV, OP_DIVU: begin
        hi_out = rem;
        lo_out = quot;
      end
      OP_MADD:  {hi_out, lo_out} = acc + prod_s;
      OP_MADDU: {hi_out, lo_out} = acc + prod_u;
      OP_MSUB:  {hi_out, lo_out} = acc - prod_s;
      OP_MSUBU: {hi_out, lo_out} = acc - prod_u;
      default: begin
        hi_out = hi_in;
        lo_out = lo_in;
      end
    endcase
  end

endmodule

// File: rtl/param_mdu.sv
// Parameterised MIPS-style multiply/divide unit with HI/LO registers.
// Ports:
//   clk        single rising-edge clock
//   reset      synchronous active-high reset; aborts any op in flight
//   start      issue the op presented this cycle
//   cancel     pipeline flush; suppresses a same-cycle start only
//   op         opcode (see mdu_pkg); 10..15 are no-ops
//   src_a      rs operand
//   src_b      rt operand
//   hi, lo     HI/LO architectural registers
//   busy       registered; a multicycle op is in flight
//   will_busy  combinational busy or multicycle issue this cycle
module param_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             will_busy
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] new_hi;
  logic [WIDTH-1:0] new_lo;
  logic             div_zero;
  logic             issue;
  logic             launch;
  logic             last;

  // Requests are only honoured while idle and not flushed.
  assign issue     = start && !cancel && (state == IDLE);
  assign launch    = issue && is_multicycle(op);
  assign last      = (state == RUN) && (cnt == CNT_ONE);
  assign busy      = (state == RUN);
  assign will_busy = busy || launch;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op       (op_q),
    .src_a    (a_q),
    .src_b    (b_q),
    .hi_in    (hi),
    .lo_in    (lo),
    .hi_out   (new_hi),
    .lo_out   (new_lo),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // RUN is left at the edge that closes the final counted cycle, so a
  // new op can issue in the very first cycle busy is low.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = RUN;
      RUN:     if (last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter, operand latches and HI/LO. The counter holds the number of
  // busy cycles still to run including the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      if (launch) begin
        op_q <= op;
        a_q  <= src_a;
        b_q  <= src_b;
        cnt  <= is_div(op) ? DIV_LOAD : MUL_LOAD;
      end else if (state == RUN) begin
        cnt <= cnt - CNT_ONE;
      end
      if (last && !div_zero) begin
        hi <= new_hi;
        lo <= new_lo;
      end
      if (issue && (op == OP_MTHI)) hi <= src_a;
      if (issue && (op == OP_MTLO)) lo <= src_a;
    end
  end

endmodule

// File: tb/tb_param_mdu.sv
// Self-checking bench for param_mdu (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10).
// Fixed vectors, hand sequences for cancel/reset corners, and random ops
// checked against a plain-arithmetic HI/LO model.
module tb_param_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cancel;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        will_busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  param_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cancel    (cancel),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .will_busy (will_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] init_hi;
    logic [31:0] init_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  // Architectural effect of one issued op on HI/LO, from the ISA rules.
  task automatic modelStep(input logic [3:0] mop, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el, output int ecyc);
    logic [63:0] acc;
    logic [63:0] sp;
    logic [63:0] up;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    acc  = {m_hi, m_lo};
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sp   = 64'(sa * sb);
    up   = {32'h0, a} * {32'h0, b};
    ecyc = 0;
    case (mop)
      4'd0: begin acc = sp;       ecyc = 5; end
      4'd1: begin acc = up;       ecyc = 5; end
      4'd2: begin
        ecyc = 10;
        if (b != 0) begin
          q = sa / sb;
          r = sa % sb;
          acc = {r[31:0], q[31:0]};
        end
      end
      4'd3: begin
        ecyc = 10;
        if (b != 0) acc = {a % b, a / b};
      end
      4'd4: acc[63:32] = a;
      4'd5: acc[31:0]  = a;
      4'd6: begin acc = acc + sp; ecyc = 5; end
      4'd7: begin acc = acc + up; ecyc = 5; end
      4'd8: begin acc = acc - sp; ecyc = 5; end
      4'd9: begin acc = acc - up; ecyc = 5; end
      default: ecyc = 0;
    endcase
    eh = acc[63:32];
    el = acc[31:0];
  endtask

  // Called at a negedge with the unit idle; issues one op, counts busy
  // cycles (bounded) and checks will_busy, cycle count and HI/LO. Returns
  // at the first negedge with busy low so a following call is back-to-back.
  task automatic applyStimulus(input string name, input logic [3:0] sop,
                               input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh;
    logic [31:0] el;
    int          ecyc;
    int          n;
    modelStep(sop, a, b, eh, el, ecyc);
    start = 1'b1;
    op    = sop;
    src_a = a;
    src_b = b;
    #1;
    checkOutput({name, ".will_busy"}, 64'(will_busy), 64'(ecyc != 0));
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    checkOutput({name, ".cycles"}, 64'(n), 64'(ecyc));
    checkOutput({name, ".hi"}, 64'(hi), 64'(eh));
    checkOutput({name, ".lo"}, 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    int n;
    logic [31:0] eh;
    logic [31:0] el;
    int ecyc;

    vecs[0]  = '{"mult_neg",   4'd0, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1]  = '{"multu",      4'd1, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFE, 5};
    vecs[2]  = '{"div_m7_2",   4'd2, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{"div_ovf",    4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h0, 32'h80000000, 10};
    vecs[4]  = '{"divu_zero",  4'd3, 32'h5, 32'h0, 32'h12345678, 32'hAAAA5555, 32'h12345678, 32'hAAAA5555, 10};
    vecs[5]  = '{"maddu",      4'd7, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 5};
    vecs[6]  = '{"msub",       4'd8, 32'h1, 32'h1, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF, 5};
    vecs[7]  = '{"divu",       4'd3, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 32'h1, 32'h7FFFFFFF, 10};
    vecs[8]  = '{"div_7_m2",   4'd2, 32'h7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFD, 10};
    vecs[9]  = '{"madd_neg",   4'd6, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5};
    vecs[10] = '{"msubu",      4'd9, 32'h2, 32'h3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[11] = '{"noop",       4'd12, 32'h99, 32'h77, 32'h11, 32'h22, 32'h11, 32'h22, 0};

    reset  = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 4'd0;
    src_a  = '0;
    src_b  = '0;
    m_hi   = '0;
    m_lo   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("reset.hi", 64'(hi), 64'h0);
    checkOutput("reset.lo", 64'(lo), 64'h0);
    checkOutput("reset.busy", 64'(busy), 64'h0);
    checkOutput("reset.will_busy", 64'(will_busy), 64'h0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus({vecs[i].name, ".mthi"}, 4'd4, vecs[i].init_hi, 32'h0);
      applyStimulus({vecs[i].name, ".mtlo"}, 4'd5, vecs[i].init_lo, 32'h0);
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput({vecs[i].name, ".tbl_hi"}, 64'(hi), 64'(vecs[i].exp_hi));
      checkOutput({vecs[i].name, ".tbl_lo"}, 64'(lo), 64'(vecs[i].exp_lo));
    end

    // start with cancel: nothing issues, HI/LO untouched.
    applyStimulus("pre_cancel.mthi", 4'd4, 32'hCAFEF00D, 32'h0);
    start  = 1'b1;
    cancel = 1'b1;
    op     = 4'd0;
    src_a  = 32'h3;
    src_b  = 32'h4;
    #1;
    checkOutput("cancel_start.will_busy", 64'(will_busy), 64'h0);
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    checkOutput("cancel_start.busy", 64'(busy), 64'h0);
    checkOutput("cancel_start.hi", 64'(hi), 64'(m_hi));
    checkOutput("cancel_start.lo", 64'(lo), 64'(m_lo));

    // cancel (with a competing start) in busy cycle 2 of a MULT.
    modelStep(4'd0, 32'h00010003, 32'hFFFFFFF0, eh, el, ecyc);
    start = 1'b1;
    op    = 4'd0;
    src_a = 32'h00010003;
    src_b = 32'hFFFFFFF0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    cancel = 1'b1;
    op     = 4'd2;
    src_a  = 32'h1;
    src_b  = 32'h1;
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    n = 2;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    checkOutput("cancel_run.cycles", 64'(n), 64'(ecyc));
    checkOutput("cancel_run.hi", 64'(hi), 64'(eh));
    checkOutput("cancel_run.lo", 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;

    // reset in busy cycle 3 of a DIV, then an immediate MULT.
    start = 1'b1;
    op    = 4'd2;
    src_a = 32'h00000064;
    src_b = 32'h00000007;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    checkOutput("reset_run.busy", 64'(busy), 64'h0);
    checkOutput("reset_run.will_busy", 64'(will_busy), 64'h0);
    checkOutput("reset_run.hi", 64'(hi), 64'h0);
    checkOutput("reset_run.lo", 64'(lo), 64'h0);
    applyStimulus("post_reset_mult", 4'd0, 32'h00000009, 32'hFFFFFFFD);

    // Random ops, biased towards interesting divisors.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 5));
        2: rb = 32'hFFFFFFFF;
        3: ra = 32'h80000000;
        default: ;
      endcase
      applyStimulus("random", 4'($urandom_range(0, 15)), ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
